// File: rtl/ssd_scan_controller_if.sv
// Bus between the 4-digit seven-segment scan controller and its host/driver.
// The controller takes the slave side; whoever loads digits and watches status takes master.
interface ssd_scan_controller_if;
  logic        en;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  bcd_sel;
  logic [3:0]  an;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;
  logic        bcd_err;

  modport master (
    output en, load, bcd_in, dp_in, blank_lz,
    input  bcd_sel, an, dp_n, pending, frame_tick, bcd_err
  );

  modport slave (
    input  en, load, bcd_in, dp_in, blank_lz,
    output bcd_sel, an, dp_n, pending, frame_tick, bcd_err
  );
endinterface

// File: rtl/ssd_scan_controller.sv
// Multiplexed 4-digit BCD display scanner with anti-ghost blanking, tear-free
// frame-boundary updates, leading-zero suppression and invalid-digit detection.
//
// state | meaning
// OFF   | display disabled, all anodes off, idx held at 0
// BLANK | start of a digit slot; digit code/dp presented, anodes off
// DRIVE | rest of the slot; anode of digit idx on unless suppressed
module ssd_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  ssd_scan_controller_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic          boundary;

  logic [15:0] disp, disp_nx, pend_bcd;
  logic [3:0]  disp_dp, disp_dp_nx, pend_dp;
  logic        disp_lz, disp_lz_nx, pend_lz;
  logic        pend_flag, pend_flag_nx, tick_nx;

  logic [3:0] dig, upper_zero;
  logic [3:0] an_nx, sel_nx;
  logic       dpn_nx, err_nx;
  logic [3:0] an_q, sel_q;
  logic       dpn_q, tick_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OFF;
      cnt       <= '0;
      idx       <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      disp_lz   <= 1'b0;
      pend_bcd  <= '0;
      pend_dp   <= '0;
      pend_lz   <= 1'b0;
      pend_flag <= 1'b0;
      an_q      <= 4'hF;
      sel_q     <= '0;
      dpn_q     <= 1'b1;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      disp      <= disp_nx;
      disp_dp   <= disp_dp_nx;
      disp_lz   <= disp_lz_nx;
      pend_flag <= pend_flag_nx;
      if (bus.load) begin
        pend_bcd <= bus.bcd_in;
        pend_dp  <= bus.dp_in;
        pend_lz  <= bus.blank_lz;
      end
      an_q   <= an_nx;
      sel_q  <= sel_nx;
      dpn_q  <= dpn_nx;
      tick_q <= tick_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    boundary = 1'b0;
    if (!bus.en) begin
      state_nx = OFF;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
          boundary = 1'b1;
        end
        BLANK: begin
          cnt_nx = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_nx = DRIVE;
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            state_nx = BLANK;
            boundary = (idx == 2'd3);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = OFF;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
    // A load coinciding with a boundary stays pending; the boundary applies older data.
    tick_nx      = boundary & pend_flag;
    disp_nx      = tick_nx ? pend_bcd : disp;
    disp_dp_nx   = tick_nx ? pend_dp  : disp_dp;
    disp_lz_nx   = tick_nx ? pend_lz  : disp_lz;
    pend_flag_nx = bus.load | (pend_flag & ~tick_nx);
  end

  // Outputs are computed from next-cycle state so the registered copies line up with it.
  always_comb begin
    dig           = disp_nx[{idx_nx, 2'b00} +: 4];
    upper_zero[0] = 1'b0;
    upper_zero[1] = (disp_nx[15:4]  == 12'h000);
    upper_zero[2] = (disp_nx[15:8]  == 8'h00);
    upper_zero[3] = (disp_nx[15:12] == 4'h0);
    an_nx  = 4'hF;
    sel_nx = 4'h0;
    dpn_nx = 1'b1;
    err_nx = err_q;
    if (state_nx != OFF) begin
      sel_nx = dig;
      dpn_nx = ~disp_dp_nx[idx_nx];
      if (state_nx == DRIVE) begin
        if (dig > 4'd9)
          err_nx = 1'b1;
        else if (!(disp_lz_nx && upper_zero[idx_nx]))
          an_nx = ~(4'b0001 << idx_nx);
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.bcd_sel    = sel_q;
  assign bus.dp_n       = dpn_q;
  assign bus.pending    = pend_flag;
  assign bus.frame_tick = tick_q;
  assign bus.bcd_err    = err_q;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: time-in-frame arithmetic model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_ssd_scan_controller;
  localparam int R = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   bad = 0;

  ssd_scan_controller_if bus();

  ssd_scan_controller #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // model: scan position is just cycles elapsed since the display was switched on
  bit          m_on;
  int          m_t;
  logic [15:0] m_disp, m_pd;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_dlz, m_plz, m_pnd, m_tk, m_err;
  logic [3:0]  m_an, m_sel;
  logic        m_dpn;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int idx, off;
    logic [3:0] dig;
    logic bnd;
    bit lit;
    if (rst) begin
      m_on = 0; m_t = 0;
      m_disp = '0; m_ddp = '0; m_dlz = 0;
      m_pd = '0; m_pdp = '0; m_plz = 0;
      m_pnd = 0; m_tk = 0; m_err = 0;
      m_an = 4'hF; m_sel = 4'h0; m_dpn = 1'b1;
    end else begin
      bnd = 1'b0;
      if (!bus.en) m_on = 0;
      else if (!m_on) begin m_on = 1; m_t = 0; bnd = 1'b1; end
      else begin m_t = m_t + 1; bnd = ((m_t % (4*R)) == 0); end
      m_tk = bnd && m_pnd;
      if (m_tk) begin m_disp = m_pd; m_ddp = m_pdp; m_dlz = m_plz; end
      if (bus.load) begin
        m_pd = bus.bcd_in; m_pdp = bus.dp_in; m_plz = bus.blank_lz; m_pnd = 1'b1;
      end else if (m_tk) m_pnd = 1'b0;
      m_an = 4'hF; m_sel = 4'h0; m_dpn = 1'b1;
      if (m_on) begin
        idx = (m_t / R) % 4;
        off = m_t % R;
        dig = 4'((m_disp >> (4*idx)) & 16'h000F);
        m_sel = dig;
        m_dpn = ~m_ddp[idx];
        lit = (off >= B) && (dig <= 4'd9) &&
              !(m_dlz && idx != 0 && (m_disp >> (4*idx)) == 16'h0000);
        if (lit) m_an = ~(4'b0001 << idx);
        if (off >= B && dig > 4'd9) m_err = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step();
    chk("an",         16'(bus.an),         16'(m_an));
    chk("bcd_sel",    16'(bus.bcd_sel),    16'(m_sel));
    chk("dp_n",       16'(bus.dp_n),       16'(m_dpn));
    chk("pending",    16'(bus.pending),    16'(m_pnd));
    chk("frame_tick", 16'(bus.frame_tick), 16'(m_tk));
    chk("bcd_err",    16'(bus.bcd_err),    16'(m_err));
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    bus.load = 1'b1; bus.bcd_in = v; bus.dp_in = dp; bus.blank_lz = lz;
    cyc(1);
    bus.load = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (bus.frame_tick !== 1'b1 && n < 80) begin cyc(1); n++; end
    chk({name, " tick"}, 16'(bus.frame_tick), 16'h0001);
  endtask

  // called on the first cycle of a frame; counts lit cycles per slot
  task automatic scan_frame(input string name, input logic [15:0] exp, input logic [3:0] lit);
    int lows;
    int ticks = 0;
    for (int s = 0; s < 4; s++) begin
      lows = 0;
      for (int c = 0; c < R; c++) begin
        if (bus.an == ~(4'b0001 << s)) lows++;
        if (bus.frame_tick) ticks++;
        if (c == R/2) chk({name, " sel"}, 16'(bus.bcd_sel), 16'(exp[4*s +: 4]));
        cyc(1);
      end
      chk({name, " lows"}, 16'(lows), 16'(lit[s] ? R-B : 0));
    end
    chk({name, " ticks"}, 16'(ticks), 16'h0001);
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.bcd_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    rst = 1'b1;
    cyc(3);
    chk("rst an",   16'(bus.an),         16'h000F);
    chk("rst sel",  16'(bus.bcd_sel),    16'h0000);
    chk("rst dp_n", 16'(bus.dp_n),       16'h0001);
    chk("rst pend", 16'(bus.pending),    16'h0000);
    chk("rst tick", 16'(bus.frame_tick), 16'h0000);
    chk("rst err",  16'(bus.bcd_err),    16'h0000);
    rst = 1'b0;
    bus.en = 1'b1;
    cyc(1);

    do_load(16'h1234, 4'b0100, 1'b0);
    chk("load pend", 16'(bus.pending), 16'h0001);
    wait_tick("f1234");
    scan_frame("f1234", 16'h1234, 4'hF);

    cyc(12);
    do_load(16'h5678, 4'b0000, 1'b0);
    chk("tear pend", 16'(bus.pending), 16'h0001);
    cyc(8);
    chk("tear old digit", 16'(bus.bcd_sel), 16'h0002);
    wait_tick("f5678");
    scan_frame("f5678", 16'h5678, 4'hF);

    do_load(16'h1111, 4'b0001, 1'b0);
    cyc(3);
    do_load(16'h2222, 4'b0010, 1'b0);
    wait_tick("coll");
    scan_frame("coll", 16'h2222, 4'hF);

    cyc(31);
    do_load(16'h9876, 4'b1000, 1'b0);
    chk("edge tick", 16'(bus.frame_tick), 16'h0000);
    chk("edge pend", 16'(bus.pending),    16'h0001);
    wait_tick("edge");
    scan_frame("edge", 16'h9876, 4'hF);

    do_load(16'h3333, 4'b0000, 1'b0);
    cyc(30);
    do_load(16'h4444, 4'b0000, 1'b0);
    chk("edge2 tick", 16'(bus.frame_tick), 16'h0001);
    chk("edge2 pend", 16'(bus.pending),    16'h0001);
    scan_frame("edge2 old", 16'h3333, 4'hF);
    wait_tick("edge2 new");
    scan_frame("edge2 new", 16'h4444, 4'hF);

    do_load(16'h0040, 4'b0000, 1'b1);
    wait_tick("lz40");
    scan_frame("lz40", 16'h0040, 4'b0011);
    do_load(16'h0000, 4'b0000, 1'b1);
    wait_tick("lz00");
    scan_frame("lz00", 16'h0000, 4'b0001);

    do_load(16'h00A1, 4'b0000, 1'b0);
    chk("err before", 16'(bus.bcd_err), 16'h0000);
    wait_tick("bad");
    scan_frame("bad", 16'h00A1, 4'b1101);
    chk("err after", 16'(bus.bcd_err), 16'h0001);

    cyc(2);
    bus.en = 1'b0;
    cyc(1);
    chk("en off an", 16'(bus.an), 16'h000F);
    bus.en = 1'b1;
    cyc(1);
    chk("restart blank0", 16'(bus.an), 16'h000F);
    cyc(1);
    chk("restart blank1", 16'(bus.an), 16'h000F);
    cyc(1);
    chk("restart drive", 16'(bus.an), 16'h000E);
    chk("err sticky", 16'(bus.bcd_err), 16'h0001);

    rst = 1'b1;
    bus.load = 1'b1; bus.bcd_in = 16'h7777;
    cyc(1);
    chk("rst drive an", 16'(bus.an),      16'h000F);
    chk("rst load pend", 16'(bus.pending), 16'h0000);
    chk("rst err clr",  16'(bus.bcd_err), 16'h0000);
    rst = 1'b0;
    bus.load = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      for (int k = 0; k < 4; k++)
        v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 499) == 0);
      bus.en       = ($urandom_range(0, 39) != 0);
      bus.load     = ($urandom_range(0, 11) == 0);
      bus.bcd_in   = v;
      bus.dp_in    = 4'($urandom_range(0, 15));
      bus.blank_lz = 1'($urandom_range(0, 1));
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
